// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with a mode select.
//   Modes: hold, masked parallel load, logical shift left/right with serial
//   fill, rotate left/right, increment and decrement. A registered carry
//   captures the shifted-out bit, the increment carry or the decrement borrow.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (q=RESET_VALUE, carry=0)
//   enable  - when 0, q and carry hold for every mode
//   mode    - operation select (see universal_register_pkg::mode_e)
//   d       - parallel load data
//   wmask   - per-bit load mask, only meaningful in LOAD
//   ser_in  - serial fill bit for SHL/SHR
//   q       - registered value
//   q_comp  - ~q (combinational)
//   carry   - registered carry / borrow / shifted-out bit
//   zero    - q == 0 (combinational)

package universal_register_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;
endpackage

// One bit of the register. Each bit sees its candidate next values (already
// routed from its neighbours by the top) and selects by mode. The flop clears
// or presets asynchronously according to its RESET_VALUE bit.
module universal_register_bit
  import universal_register_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] mode,
  input  logic       ld_bit,
  input  logic       shl_bit,
  input  logic       shr_bit,
  input  logic       rotl_bit,
  input  logic       rotr_bit,
  input  logic       inc_bit,
  input  logic       dec_bit,
  output logic       q_bit
);
  logic nxt;

  always_comb begin
    nxt = q_bit;
    case (mode)
      MODE_HOLD: nxt = q_bit;
      MODE_LOAD: nxt = ld_bit;
      MODE_SHL:  nxt = shl_bit;
      MODE_SHR:  nxt = shr_bit;
      MODE_ROTL: nxt = rotl_bit;
      MODE_ROTR: nxt = rotr_bit;
      MODE_INC:  nxt = inc_bit;
      MODE_DEC:  nxt = dec_bit;
      default:   nxt = q_bit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q_bit <= RST_BIT;
    else if (enable) q_bit <= nxt;
  end
endmodule

module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] wmask,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_comp,
  output logic             carry,
  output logic             zero
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Candidate next values for every mode, computed as whole vectors so the
  // per-bit cells only have to pick one.
  logic [WIDTH-1:0] ld_v, shl_v, shr_v, rotl_v, rotr_v, inc_v, dec_v;
  logic             carry_nxt;

  always_comb begin
    ld_v   = (q & ~wmask) | (d & wmask);
    shl_v  = {q[WIDTH-2:0], ser_in};
    shr_v  = {ser_in, q[WIDTH-1:1]};
    rotl_v = {q[WIDTH-2:0], q[WIDTH-1]};
    rotr_v = {q[0], q[WIDTH-1:1]};
    inc_v  = q + ONE;
    dec_v  = q - ONE;
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      universal_register_bit #(.RST_BIT(RESET_VALUE[i])) u_bit (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .ld_bit   (ld_v[i]),
        .shl_bit  (shl_v[i]),
        .shr_bit  (shr_v[i]),
        .rotl_bit (rotl_v[i]),
        .rotr_bit (rotr_v[i]),
        .inc_bit  (inc_v[i]),
        .dec_bit  (dec_v[i]),
        .q_bit    (q[i])
      );
    end
  endgenerate

  // Carry: wrap detection uses the pre-edge q, so INC carries only from all
  // ones and DEC borrows only from zero. An unrecognised mode holds.
  always_comb begin
    carry_nxt = carry;
    case (mode)
      MODE_HOLD: carry_nxt = carry;
      MODE_LOAD: carry_nxt = 1'b0;
      MODE_SHL:  carry_nxt = q[WIDTH-1];
      MODE_SHR:  carry_nxt = q[0];
      MODE_ROTL: carry_nxt = q[WIDTH-1];
      MODE_ROTR: carry_nxt = q[0];
      MODE_INC:  carry_nxt = &q;
      MODE_DEC:  carry_nxt = ~|q;
      default:   carry_nxt = carry;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      carry <= 1'b0;
    else if (enable) carry <= carry_nxt;
  end

  assign q_comp = ~q;
  assign zero   = ~|q;
endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the team's fixed 32-bit enable register: a WIDTH-bit register with a mode select.
- Modes: hold, masked parallel load, logical shift left/right with serial fill, rotate left/right, increment and decrement.
- Provides carry/borrow and zero status. Drops in wherever the datapath needs a loadable, shiftable or counting register (accumulators, shifters, program counters).

Parameters:
- WIDTH, 32, register width in bits; legal range is WIDTH >= 2.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset.
- enable  input  1  when 0, q and carry hold regardless of mode.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- wmask  input  WIDTH  per-bit load mask; used only in LOAD.
- ser_in  input  1  serial fill bit for the shift modes.
- q  output  WIDTH  registered value.
- q_comp  output  WIDTH  bitwise complement of q (combinational).
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  high when q is all zeros (combinational).

Interface (already decided): one clock; reset is asynchronous and active-low.
- Clock port: clk.
- Reset port: rst_n.

Behaviour:
- Reset:
  - rst_n=0 immediately (asynchronously) forces q=RESET_VALUE and carry=0. It dominates enable and mode.
  - It takes effect mid-operation with no clock needed.
  - After rst_n rises, the first update occurs on the first rising clk edge with enable=1.
  - Reset values: q=RESET_VALUE, q_comp=~RESET_VALUE, carry=0, zero=(RESET_VALUE==0).
- Updates happen only on a rising clk edge with enable=1. Latency is 1 cycle: the new q is visible after the edge.
- q_comp and zero are pure functions of q and carry no extra latency.
- Mode encoding and effect (q' and carry' are the values after the edge):
  - 000 HOLD: q'=q, carry'=carry.
  - 001 LOAD: q'=(q & ~wmask) | (d & wmask); carry'=0. wmask=0 leaves q unchanged but still clears carry.
  - 010 SHL: q'={q[WIDTH-2:0], ser_in}; carry'=q[WIDTH-1].
  - 011 SHR: q'={ser_in, q[WIDTH-1:1]}; carry'=q[0].
  - 100 ROTL: q'={q[WIDTH-2:0], q[WIDTH-1]}; carry'=q[WIDTH-1].
  - 101 ROTR: q'={q[0], q[WIDTH-1:1]}; carry'=q[0].
  - 110 INC: q'=q+1 modulo 2^WIDTH; carry'=1 only when q was all ones (wrap to 0), else 0.
  - 111 DEC: q'=q-1 modulo 2^WIDTH; carry'=1 (borrow) only when q was 0 (wrap to all ones), else 0.
- Arithmetic is unsigned. No sign extension; bits never leave the WIDTH range except via carry.
- enable=0: q and carry are unchanged for every mode, including LOAD.
- mode, d, wmask and ser_in are sampled only at the edge. Changes between edges have no effect on q.
- X or Z on mode while enable=1 is illegal; the bench flags it as an error.
- The implementation is synchronous-RTL per-bit flip-flops with async clear/preset from RESET_VALUE. No latches and no combinational feedback loops.

Test Plan (WIDTH=8, RESET_VALUE=8'hA5 unless noted):
- Reset: assert rst_n=0 between clock edges -> q=8'hA5, q_comp=8'h5A, carry=0 before the next edge. Hold rst_n=0 over 3 edges with enable=1, mode=INC -> q stays 8'hA5.
- Masked load: LOAD d=8'h3C, wmask=8'h0F from q=8'hA5 -> q=8'hAC, carry=0. Next edge with enable=0 and mode=LOAD, d=8'hFF -> q stays 8'hAC.
- Shifts:
  - From q=8'h81: SHL ser_in=1 -> q=8'h03, carry=1.
  - Then SHR ser_in=0 -> q=8'h01, carry=1.
  - Then ROTR -> q=8'h80, carry=1.
  - Then ROTL -> q=8'h01, carry=1.
- Counter wrap:
  - LOAD 8'hFE, then INC x2 -> q=8'hFF (carry=0), then q=8'h00 (carry=1, zero=1).
  - Then DEC -> q=8'hFF, carry=1, zero=0.
  - Then DEC -> q=8'hFE, carry=0.
- Async reset mid-stream: run INC for 5 cycles from 8'h10 and pull rst_n low 2 time units after the 3rd edge -> q jumps to 8'hA5 at once. Release and INC once -> q=8'hA6.
- HOLD and X check: from q=8'h55, carry=1, apply HOLD for 4 edges -> q=8'h55, carry=1 throughout. Drive mode=3'bx with enable=1 -> the bench reports an error.
